// File: rtl/poly_cmd_dispatcher.sv
// Top-level sequencer of the polynomial evaluation accelerator: command fetch,
// decode, resource gating, executor dispatch and error reporting.
// Optional executor watchdog is enabled by defining DISPATCH_WDT_EN.
module poly_cmd_dispatcher #(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned N_POLY     = 8,
  parameter int unsigned WDT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_avail,
  output logic              start_get_cmd,
  input  logic              en_rd_cmd,
  output logic              en_mode_check_err,
  input  logic              done_get_cmd,
  input  logic [7:0]        instr,
  input  logic [2:0]        arg1,
  input  logic [4:0]        arg2,
  input  logic [1:0]        error,
  input  logic [CNT_W-1:0]  data_count,
  input  logic [CNT_W-1:0]  out_free,
  output logic              start_stp,
  input  logic              done_stp,
  output logic              start_evp,
  input  logic              done_evp,
  output logic              start_evb,
  input  logic              done_evb,
  output logic              start_clr,
  input  logic              done_clr,
  output logic [2:0]        exec_arg1,
  output logic [4:0]        exec_arg2,
  output logic              err_valid,
  output logic [2:0]        err_code,
  output logic [N_POLY-1:0] loaded,
  output logic [15:0]       cmd_count
);

  localparam int unsigned TOK_W = CNT_W + 1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_FETCH    = 3'd1;
  localparam logic [2:0] ST_DECODE   = 3'd2;
  localparam logic [2:0] ST_WAIT_RES = 3'd3;
  localparam logic [2:0] ST_START    = 3'd4;
  localparam logic [2:0] ST_BUSY     = 3'd5;
  localparam logic [2:0] ST_REPORT   = 3'd6;

  localparam logic [7:0] OP_STP = 8'd0;
  localparam logic [7:0] OP_EVP = 8'd1;
  localparam logic [7:0] OP_EVB = 8'd2;
  localparam logic [7:0] OP_CLR = 8'd3;

  localparam logic [2:0] ERR_BAD_OP     = 3'd1;
  localparam logic [2:0] ERR_NOT_LOADED = 3'd3;
  localparam logic [2:0] ERR_BAD_DEGREE = 3'd2;

  localparam logic [15:0] WDT_LIMIT = 16'(WDT_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [2:0]        arg1_q, arg1_d;
  logic [4:0]        arg2_q, arg2_d;
  logic [1:0]        ferr_q, ferr_d;
  logic [N_POLY-1:0] loaded_q, loaded_d;
  logic [15:0]       cmd_count_q, cmd_count_d;
  logic [2:0]        err_code_q, err_code_d;
  logic              err_valid_q, err_valid_d;
  logic              start_get_cmd_q, start_get_cmd_d;
  logic              start_stp_q, start_stp_d;
  logic              start_evp_q, start_evp_d;
  logic              start_evb_q, start_evb_d;
  logic              start_clr_q, start_clr_d;

  logic [TOK_W-1:0]  need_in;
  logic [TOK_W-1:0]  need_out;
  logic              done_match;
  logic              res_ok;
  logic              slot_loaded;

`ifdef DISPATCH_WDT_EN
  logic [15:0]       wdt_q, wdt_d;
`else
  logic [15:0]       unused_wdt_limit;
  assign unused_wdt_limit = WDT_LIMIT;
`endif

  // The fetcher may only consume a word while the command FIFO has one.
  assign en_mode_check_err = en_rd_cmd & cmd_avail;

  // Per-opcode token requirements and the done line of the selected executor.
  always_comb begin
    need_in    = '0;
    need_out   = '0;
    done_match = 1'b0;
    case (instr_q)
      OP_STP: begin
        need_in    = TOK_W'(arg2_q) + TOK_W'(1);
        done_match = done_stp;
      end
      OP_EVP: begin
        need_in    = TOK_W'(1);
        need_out   = TOK_W'(1);
        done_match = done_evp;
      end
      OP_EVB: begin
        need_in    = TOK_W'(arg2_q);
        need_out   = TOK_W'(arg2_q);
        done_match = done_evb;
      end
      OP_CLR: done_match = done_clr;
      default: ;
    endcase
  end

  assign res_ok      = ({1'b0, data_count} >= need_in) && ({1'b0, out_free} >= need_out);
  assign slot_loaded = loaded_q[arg1_q];

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    arg1_d      = arg1_q;
    arg2_d      = arg2_q;
    ferr_d      = ferr_q;
    loaded_d    = loaded_q;
    cmd_count_d = cmd_count_q;
    err_code_d  = 3'd0;
`ifdef DISPATCH_WDT_EN
    wdt_d       = 16'd0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (cmd_avail) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (done_get_cmd) begin
          instr_d = instr;
          arg1_d  = arg1;
          arg2_d  = arg2;
          ferr_d  = error;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (ferr_q != 2'd0) begin
          state_d    = ST_REPORT;
          err_code_d = {1'b0, ferr_q};
        end else if (instr_q > OP_CLR) begin
          state_d    = ST_REPORT;
          err_code_d = ERR_BAD_OP;
        end else if ((instr_q == OP_EVP || instr_q == OP_EVB) && !slot_loaded) begin
          state_d    = ST_REPORT;
          err_code_d = ERR_NOT_LOADED;
        end else if (instr_q == OP_EVB && arg2_q == 5'd0) begin
          state_d    = ST_REPORT;
          err_code_d = ERR_BAD_DEGREE;
        end else begin
          state_d = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        if (res_ok) state_d = ST_START;
      end
      ST_START: begin
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (done_match) begin
          if (instr_q == OP_STP) begin
            loaded_d[arg1_q] = 1'b1;
          end else if (instr_q == OP_CLR) begin
            loaded_d = '0;
          end
          cmd_count_d = cmd_count_q + 16'd1;
          state_d     = ST_IDLE;
        end
`ifdef DISPATCH_WDT_EN
        else if (wdt_q == WDT_LIMIT) begin
          state_d    = ST_REPORT;
          err_code_d = 3'd4;
        end else begin
          wdt_d = wdt_q + 16'd1;
        end
`endif
      end
      ST_REPORT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Strobes are registered copies of the state being entered.
    start_get_cmd_d = (state_d == ST_FETCH);
    start_stp_d     = (state_d == ST_START) && (instr_q == OP_STP);
    start_evp_d     = (state_d == ST_START) && (instr_q == OP_EVP);
    start_evb_d     = (state_d == ST_START) && (instr_q == OP_EVB);
    start_clr_d     = (state_d == ST_START) && (instr_q == OP_CLR);
    err_valid_d     = (state_d == ST_REPORT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      instr_q         <= 8'd0;
      arg1_q          <= 3'd0;
      arg2_q          <= 5'd0;
      ferr_q          <= 2'd0;
      loaded_q        <= '0;
      cmd_count_q     <= 16'd0;
      err_code_q      <= 3'd0;
      err_valid_q     <= 1'b0;
      start_get_cmd_q <= 1'b0;
      start_stp_q     <= 1'b0;
      start_evp_q     <= 1'b0;
      start_evb_q     <= 1'b0;
      start_clr_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      arg1_q          <= arg1_d;
      arg2_q          <= arg2_d;
      ferr_q          <= ferr_d;
      loaded_q        <= loaded_d;
      cmd_count_q     <= cmd_count_d;
      err_code_q      <= err_code_d;
      err_valid_q     <= err_valid_d;
      start_get_cmd_q <= start_get_cmd_d;
      start_stp_q     <= start_stp_d;
      start_evp_q     <= start_evp_d;
      start_evb_q     <= start_evb_d;
      start_clr_q     <= start_clr_d;
    end
  end

`ifdef DISPATCH_WDT_EN
  // Watchdog counts consecutive BUSY cycles and clears everywhere else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdt_q <= 16'd0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`endif

  assign start_get_cmd = start_get_cmd_q;
  assign start_stp     = start_stp_q;
  assign start_evp     = start_evp_q;
  assign start_evb     = start_evb_q;
  assign start_clr     = start_clr_q;
  assign exec_arg1     = arg1_q;
  assign exec_arg2     = arg2_q;
  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;
  assign loaded        = loaded_q;
  assign cmd_count     = cmd_count_q;

endmodule
